// File: rtl/fifo_rd_stream.sv
// Read-side output stage of the async FIFO (rclk domain).
// Turns the pop interface (rinc/rempty, synchronous-read rdata one cycle
// after the pop edge) into a valid/ready stream. A two-entry buffer absorbs
// the memory read latency so one word per cycle is sustained when m_ready is
// held high. m_valid, m_data and occ all come straight from flops.
module fifo_rd_stream #(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  output logic             rinc,
  input  logic [DSIZE-1:0] rdata,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready,
  output logic [1:0]       occ
);

  logic [1:0]       cnt;
  logic             infl;
  logic [DSIZE-1:0] buf0;
  logic [DSIZE-1:0] buf1;

  logic       drain;
  logic [1:0] remain;
  logic [1:0] cnt_nxt;

  // Occupancy bookkeeping and pop decision. cnt + infl never exceeds 2, so
  // remain + infl fits in two bits. A pop is only issued when the word it
  // returns next cycle is guaranteed a free slot.
  always_comb begin
    drain   = m_valid & m_ready;
    remain  = cnt - {1'b0, drain};
    cnt_nxt = remain + {1'b0, infl};
    rinc    = ~rempty & (cnt_nxt < 2'd2);
  end

  // Occupancy, in-flight flag and the registered valid (mirrors cnt != 0).
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      cnt     <= 2'd0;
      infl    <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      infl    <= rinc;
      m_valid <= (cnt_nxt != 2'd0);
    end
  end

  // Data movement: shift buf1 into the head on a drain from a full buffer,
  // and land the in-flight word in the first slot left free after the drain.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      if (drain && (cnt == 2'd2)) begin
        buf0 <= buf1;
      end
      if (infl) begin
        if (remain == 2'd0) begin
          buf0 <= rdata;
        end else if (remain == 2'd1) begin
          buf1 <= rdata;
        end
      end
    end
  end

  assign m_data = buf0;
  assign occ    = cnt;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: an upstream FIFO model (memory + read pointer +
// registered empty), a queue scoreboard of popped-but-not-accepted words, a
// per-cycle compare process and directed phases with literal expectations.
module tb_fifo_rd_stream;
  localparam int DSIZE = 8;

  logic             rclk;
  logic             rrst_n;
  logic             rempty;
  logic             rinc;
  logic [DSIZE-1:0] rdata;
  logic             m_valid;
  logic [DSIZE-1:0] m_data;
  logic             m_ready;
  logic [1:0]       occ;

  int n_tests = 0;
  int n_fail  = 0;

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  fifo_rd_stream #(.DSIZE(DSIZE)) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rempty  (rempty),
    .rinc    (rinc),
    .rdata   (rdata),
    .m_valid (m_valid),
    .m_data  (m_data),
    .m_ready (m_ready),
    .occ     (occ)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Upstream FIFO model: words mem[0..wr_cnt-1] are available.
  logic [7:0] mem [0:63];
  int wr_cnt;
  int rd_ptr;

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rd_ptr <= 0;
      rempty <= 1'b1;
      rdata  <= '0;
    end else begin
      if (rinc) rdata <= mem[rd_ptr % 64];
      rd_ptr <= rd_ptr + int'(rinc);
      rempty <= ((rd_ptr + int'(rinc)) >= wr_cnt);
    end
  end

  // Scoreboard: queue of words popped but not yet accepted downstream.
  logic [7:0] q [$];
  bit         pend;
  logic [7:0] got [0:63];
  int         n_got;

  always @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      q.delete();
      pend = 1'b0;
    end else begin
      if (m_valid && m_ready && (q.size() > 0)) begin
        got[n_got % 64] = m_data;
        n_got++;
        void'(q.pop_front());
      end
      if (rinc) q.push_back(mem[rd_ptr % 64]);
      pend = rinc;
    end
  end

  // Per-cycle compare plus statistics for the directed checks.
  int   exp_occ;
  bit   exp_valid;
  bit   exp_rinc;
  bit   hold_prev;
  logic [7:0] prev_data;
  int   cyc, rinc_cnt, rinc_run, rinc_run_max, val_cnt, val_run, val_run_max;
  int   first_rinc, first_val, occ_max;

  always @(negedge rclk) begin
    if (rrst_n) begin
      exp_occ   = q.size() - int'(pend);
      exp_valid = (exp_occ != 0);
      exp_rinc  = !rempty && ((q.size() - int'(exp_valid && m_ready)) < 2);
      chk("occ", int'(occ), exp_occ);
      chk("m_valid", int'(m_valid), int'(exp_valid));
      chk("rinc", int'(rinc), int'(exp_rinc));
      if (exp_valid && (q.size() > 0)) chk("m_data", int'(m_data), int'(q[0]));
      if (hold_prev) chk("m_data_hold", int'(m_data), int'(prev_data));
      hold_prev = m_valid && !m_ready;
      prev_data = m_data;
      cyc++;
      if (rinc) begin
        rinc_cnt++;
        rinc_run++;
        if (rinc_run > rinc_run_max) rinc_run_max = rinc_run;
        if (first_rinc < 0) first_rinc = cyc;
      end else begin
        rinc_run = 0;
      end
      if (m_valid) begin
        val_cnt++;
        val_run++;
        if (val_run > val_run_max) val_run_max = val_run;
        if (first_val < 0) first_val = cyc;
      end else begin
        val_run = 0;
      end
      if (int'(occ) > occ_max) occ_max = int'(occ);
    end else begin
      hold_prev = 1'b0;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge rclk);
      #1;
    end
  endtask

  task automatic clr();
    cyc = 0; rinc_cnt = 0; rinc_run = 0; rinc_run_max = 0;
    val_cnt = 0; val_run = 0; val_run_max = 0;
    first_rinc = -1; first_val = -1; occ_max = 0; n_got = 0;
  endtask

  task automatic do_reset();
    rrst_n  = 1'b0;
    wr_cnt  = 0;
    m_ready = 1'b0;
    wait_cyc(2);
    rrst_n = 1'b1;
  endtask

  task automatic load(input int base, input int n);
    for (int i = 0; i < n; i++) mem[i] = 8'(base + i);
  endtask

  int got_before;

  initial begin
    rrst_n  = 1'b1;
    m_ready = 1'b0;
    wr_cnt  = 0;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    clr();
    #1 rrst_n = 1'b0;
    m_ready = 1'b1;
    wait_cyc(3);
    chk("rst_rinc", int'(rinc), 0);
    chk("rst_m_valid", int'(m_valid), 0);
    chk("rst_m_data", int'(m_data), 0);
    chk("rst_occ", int'(occ), 0);
    rrst_n  = 1'b1;
    m_ready = 1'b0;

    // single word
    mem[0] = 8'hA5;
    clr();
    wr_cnt  = 1;
    m_ready = 1'b1;
    wait_cyc(8);
    chk("single_rinc_cycles", rinc_cnt, 1);
    chk("single_valid_cycles", val_cnt, 1);
    chk("single_latency", first_val - first_rinc, 2);
    chk("single_n_got", n_got, 1);
    chk("single_data", int'(got[0]), 'hA5);
    chk("single_occ_end", int'(occ), 0);

    // streaming 8 words
    do_reset();
    load('h10, 8);
    clr();
    wr_cnt  = 8;
    m_ready = 1'b1;
    wait_cyc(14);
    chk("stream_rinc_cnt", rinc_cnt, 8);
    chk("stream_rinc_run", rinc_run_max, 8);
    chk("stream_val_cnt", val_cnt, 8);
    chk("stream_val_run", val_run_max, 8);
    chk("stream_n_got", n_got, 8);
    chk("stream_first", int'(got[0]), 'h10);
    chk("stream_last", int'(got[7]), 'h17);

    // backpressure
    do_reset();
    load('h20, 5);
    clr();
    wr_cnt  = 5;
    m_ready = 1'b0;
    wait_cyc(8);
    chk("bp_pops", rinc_cnt, 2);
    chk("bp_occ", int'(occ), 2);
    chk("bp_rinc_low", int'(rinc), 0);
    chk("bp_head", int'(m_data), 'h20);
    chk("bp_n_got", n_got, 0);
    m_ready = 1'b1;
    @(negedge rclk);
    chk("bp_rinc_same_cycle", int'(rinc), 1);
    wait_cyc(10);
    chk("bp_n_got_end", n_got, 5);
    chk("bp_got0", int'(got[0]), 'h20);
    chk("bp_got4", int'(got[4]), 'h24);

    // asynchronous reset mid-stream
    do_reset();
    load('h30, 8);
    clr();
    wr_cnt  = 8;
    m_ready = 1'b1;
    wait_cyc(4);
    chk("mid_occ_before", int'(occ), 1);
    #2 rrst_n = 1'b0;
    wr_cnt = 0;
    #1;
    chk("mid_rst_m_valid", int'(m_valid), 0);
    chk("mid_rst_m_data", int'(m_data), 0);
    chk("mid_rst_occ", int'(occ), 0);
    chk("mid_rst_rinc", int'(rinc), 0);
    wait_cyc(2);
    rrst_n = 1'b1;
    got_before = n_got;
    wait_cyc(6);
    chk("mid_no_stale", n_got, got_before);
    chk("mid_occ_after", int'(occ), 0);

    // toggling m_ready over 16 words
    do_reset();
    load('h40, 16);
    clr();
    wr_cnt = 16;
    for (int k = 0; k < 80; k++) begin
      m_ready = ((k % 2) == 0);
      wait_cyc(1);
    end
    m_ready = 1'b1;
    wait_cyc(4);
    chk("tog_n_got", n_got, 16);
    for (int i = 0; i < 16; i++) chk("tog_order", int'(got[i]), 'h40 + i);
    chk("tog_occ_max_le2", int'(occ_max <= 2), 1);

    // rempty rises right after a pop, with m_ready low
    do_reset();
    mem[0] = 8'h5A;
    mem[1] = 8'h5B;
    clr();
    wr_cnt  = 1;
    m_ready = 1'b0;
    wait_cyc(6);
    chk("race_occ", int'(occ), 1);
    chk("race_pops", rinc_cnt, 1);
    chk("race_rinc_low", int'(rinc), 0);
    wr_cnt = 2;
    @(posedge rclk);
    @(negedge rclk);
    chk("race_rinc_resume", int'(rinc), 1);
    wait_cyc(1);
    m_ready = 1'b1;
    wait_cyc(8);
    chk("race_n_got", n_got, 2);
    chk("race_got0", int'(got[0]), 'h5A);
    chk("race_got1", int'(got[1]), 'h5B);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
